alu_seq_unit: RTL and testbench

Parametrised sequential ALU with a valid/ready handshake on both request and response sides. Single-cycle logic and arithmetic ops complete in one cycle. Multiply and divide run as iterative multi-cycle operations under a small FSM. It sits between an opcode-decoding front end and a result sink, and is the handshaked, width-generic successor to the combinational opcode ALU.

---
 rtl/alu_seq_unit.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked, width-generic sequential ALU.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHR) respond one cycle after accept.
// MUL (shift-add) and DIV (restoring) iterate WIDTH times in CALC.
// Build option: define ALU_MULDIV_EN to include the iterative MUL/DIV datapath.
// Without it, opcodes 110/111 respond in one cycle with err=1.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | MUL/DIV iterating (ALU_MULDIV_EN builds only)
// DONE  | response valid, held until out_ready
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] ext,
  output logic             err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
`ifdef ALU_MULDIV_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  logic             err_q, err_d;
  logic             accept;

`ifdef ALU_MULDIV_EN
  // {hi, lo} is the product (MUL) or {remainder, quotient} (DIV) being built;
  // opnd holds the multiplicand or divisor.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shl;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  // One shift-add (MUL) or restoring-subtract (DIV) step on {hi, lo}
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shl = {hi_q, lo_q[WIDTH-1]};
    if (is_div_q) begin
      // remainder stays below the divisor, so the difference fits in WIDTH bits
      if (div_shl >= {1'b0, opnd_q}) begin
        iter_hi = div_shl[WIDTH-1:0] - opnd_q;
        iter_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shl[WIDTH-1:0];
        iter_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end
`endif

  assign in_ready  = (state_q == IDLE) && rstN;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ext       = ext_q;
  assign err       = err_q;

  // Next-state and registered-result computation
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ext_d    = ext_q;
    err_d    = err_q;
`ifdef ALU_MULDIV_EN
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DONE;
          ext_d   = '0;
          err_d   = 1'b0;
          case (opcode)
            OP_ADD: result_d = a + b;
            OP_SUB: result_d = a - b;
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            // a shift count of WIDTH or more yields zero
            OP_SHR: result_d = a >> b;
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
              state_d  = CALC;
              hi_d     = '0;
              lo_d     = b;
              opnd_d   = a;
              is_div_d = 1'b0;
              cnt_d    = CNT_LOAD;
            end
            OP_DIV: begin
              if (b == '0) begin
                result_d = '1;
                ext_d    = a;
                err_d    = 1'b1;
              end else begin
                state_d  = CALC;
                hi_d     = '0;
                lo_d     = a;
                opnd_d   = b;
                is_div_d = 1'b1;
                cnt_d    = CNT_LOAD;
              end
            end
`else
            default: begin
              result_d = '0;
              ext_d    = '0;
              err_d    = 1'b1;
            end
`endif
          endcase
        end
      end
`ifdef ALU_MULDIV_EN
      CALC: begin
        hi_d  = iter_hi;
        lo_d  = iter_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          result_d = iter_lo;
          ext_d    = iter_hi;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= IDLE;
      result_q <= '0;
      ext_q    <= '0;
      err_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ext_q    <= ext_d;
      err_q    <= err_d;
`ifdef ALU_MULDIV_EN
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=8); follows ALU_MULDIV_EN if defined.
module tb_alu_seq_unit;

  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;
  localparam int NVEC = 17;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] ext;
    logic         err;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] ext;
    logic         err;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [W-1:0] ext;
  logic         err;

  exp_t sb_q[$];
  vec_t tbl[NVEC];
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ext      (ext),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] e,
                                output logic er, output int lat);
    logic [2*W-1:0] p;
    r = '0; e = '0; er = 1'b0; lat = 1; p = '0;
    case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHR: r = (int'(y) >= W) ? '0 : x >> y;
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        p = (2*W)'(x) * (2*W)'(y);
        r = p[W-1:0]; e = p[2*W-1:W]; lat = W + 1;
      end
      default: begin
        if (y == '0) begin
          r = '1; e = x; er = 1'b1;
        end else begin
          r = x / y; e = x % y; lat = W + 1;
        end
      end
`else
      default: er = 1'b1;
`endif
    endcase
  endfunction

  // drive one request; returns at the falling edge after the accept edge
  task automatic issue(input string nm, input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; a = ia; b = ib;
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic take_resp(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_sb: got a response, expected none pending", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_res"}, 32'(result), 32'(e.res));
      chk({nm, "_ext"}, 32'(ext), 32'(e.ext));
      chk({nm, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] er, input logic [W-1:0] ee, input logic eerr, input int elat);
    exp_t e;
    int   n;
    logic rdy_seen;
    e.res = er; e.ext = ee; e.err = eerr;
    sb_q.push_back(e);
    issue(nm, op, ia, ib);
    n = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 100) begin
      rdy_seen |= in_ready;
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(elat));
    chk({nm, "_busy"}, 32'(rdy_seen | in_ready), 32'd0);
    take_resp(nm);
    @(negedge clk);
    chk({nm, "_retire"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] rr, re;
    logic         rerr;
    int           rl;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic         seen;

    tbl[0]  = '{OP_ADD, 8'd5,   8'd3,   8'd8,   8'h00, 1'b0, 1};
    tbl[1]  = '{OP_SUB, 8'd3,   8'd5,   8'hFE,  8'h00, 1'b0, 1};
    tbl[2]  = '{OP_SHR, 8'hF0,  8'd4,   8'h0F,  8'h00, 1'b0, 1};
    tbl[3]  = '{OP_SHR, 8'hF0,  8'd9,   8'h00,  8'h00, 1'b0, 1};
    tbl[4]  = '{OP_SHR, 8'hF0,  8'd8,   8'h00,  8'h00, 1'b0, 1};
    tbl[5]  = '{OP_SHR, 8'hF0,  8'd7,   8'h01,  8'h00, 1'b0, 1};
    tbl[6]  = '{OP_AND, 8'hCC,  8'hAA,  8'h88,  8'h00, 1'b0, 1};
    tbl[7]  = '{OP_OR,  8'hCC,  8'hAA,  8'hEE,  8'h00, 1'b0, 1};
    tbl[8]  = '{OP_XOR, 8'hCC,  8'hAA,  8'h66,  8'h00, 1'b0, 1};
    tbl[9]  = '{OP_ADD, 8'hFF,  8'h02,  8'h01,  8'h00, 1'b0, 1};
`ifdef ALU_MULDIV_EN
    tbl[10] = '{OP_MUL, 8'd200, 8'd3,   8'h58,  8'h02, 1'b0, 9};
    tbl[11] = '{OP_DIV, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9};
    tbl[12] = '{OP_DIV, 8'd9,   8'd0,   8'hFF,  8'd9,  1'b1, 1};
    tbl[13] = '{OP_MUL, 8'hFF,  8'hFF,  8'h01,  8'hFE, 1'b0, 9};
    tbl[14] = '{OP_DIV, 8'hFF,  8'h01,  8'hFF,  8'h00, 1'b0, 9};
    tbl[15] = '{OP_DIV, 8'd5,   8'd9,   8'h00,  8'd5,  1'b0, 9};
    tbl[16] = '{OP_MUL, 8'd3,   8'd3,   8'd9,   8'h00, 1'b0, 9};
`else
    tbl[10] = '{OP_MUL, 8'd200, 8'd3,   8'h00,  8'h00, 1'b1, 1};
    tbl[11] = '{OP_DIV, 8'd100, 8'd7,   8'h00,  8'h00, 1'b1, 1};
    tbl[12] = '{OP_DIV, 8'd9,   8'd0,   8'h00,  8'h00, 1'b1, 1};
    tbl[13] = '{OP_MUL, 8'hFF,  8'hFF,  8'h00,  8'h00, 1'b1, 1};
    tbl[14] = '{OP_DIV, 8'hFF,  8'h01,  8'h00,  8'h00, 1'b1, 1};
    tbl[15] = '{OP_DIV, 8'd5,   8'd9,   8'h00,  8'h00, 1'b1, 1};
    tbl[16] = '{OP_MUL, 8'd3,   8'd3,   8'h00,  8'h00, 1'b1, 1};
`endif

    // reset
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", {15'd0, err, ext, result}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    // directed vectors
    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].res, tbl[i].ext, tbl[i].err, tbl[i].lat);
    end

    // random vectors against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = (rop == OP_SHR) ? W'($urandom_range(0, 12)) : W'($urandom);
      model(rop, ra, rb, rr, re, rerr, rl);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rr, re, rerr, rl);
    end

    // backpressure: response held, extra requests ignored
    out_ready = 1'b0;
    sb_q.push_back('{8'd2, 8'd0, 1'b0});
    issue("bp", OP_ADD, 8'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'd2});
      in_valid = (i == 1 || i == 3);
      opcode = OP_ADD; a = 8'd7; b = 8'd7;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    take_resp("bp");
    @(negedge clk);
    chk("bp_retire", {30'd0, out_valid, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("bp_no_extra", 32'(seen), 32'd0);

    // reset while a response is held in DONE
    out_ready = 1'b0;
    issue("rst_done", OP_ADD, 8'h30, 8'h11);
    chk("rst_done_pre", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h41});
    rstN = 1'b0;
    @(negedge clk);
    chk("rst_done_outs", {14'd0, in_ready, out_valid, err, ext, result}, 32'd0);
    rstN = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("rst_done_silent", 32'(seen), 32'd0);

`ifdef ALU_MULDIV_EN
    // reset during DIV iteration, after leaving a nonzero result behind
    run_op("pre_div", OP_XOR, 8'h5A, 8'h00, 8'h5A, 8'h00, 1'b0, 1);
    issue("rst_calc", OP_DIV, 8'd100, 8'd7);
    repeat (2) @(negedge clk);
    chk("rst_calc_busy", {30'd0, out_valid, in_ready}, 32'd0);
    rstN = 1'b0;
    @(negedge clk);
    chk("rst_calc_outs", {14'd0, in_ready, out_valid, err, ext, result}, 32'd0);
    rstN = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("rst_calc_silent", 32'(seen), 32'd0);
`endif

    run_op("post_rst_add", OP_ADD, 8'd2, 8'd2, 8'd4, 8'd0, 1'b0, 1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
